// File: rtl/core_hazard_pkg.sv
// rtl/core_hazard_pkg.sv - shared types and helpers for the multi-channel hazard unit
package core_hazard_pkg;

    typedef enum logic [1:0] {
        HZ_IDLE = 2'd0,
        HZ_REQ  = 2'd1,
        HZ_DONE = 2'd2,
        HZ_ERR  = 2'd3
    } hz_state_t;

    localparam int LOAD_LATENCY_MIN = 1;
    localparam int LOAD_LATENCY_MAX = 2;

    // A single channel still needs a one-bit index field.
    function automatic int chan_idx_w(input int n_channels);
        return (n_channels <= 1) ? 1 : $clog2(n_channels);
    endfunction

endpackage

// File: rtl/core_hazard_mc_periph_chan_decode.sv
// rtl/core_hazard_mc_periph_chan_decode.sv - address to {hit, valid, channel} decode
module periph_chan_decode
    import core_hazard_pkg::*;
#(
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int          N_CHANNELS      = 4,
    parameter int          CHAN_SHIFT      = 12,
    localparam int         CW              = chan_idx_w(N_CHANNELS)
) (
    input  logic [63:0]   addr,
    output logic          hit,
    output logic          ch_valid,
    output logic [CW-1:0] ch
);

    logic [63:0] offset;
    logic [63:0] win;

    assign offset   = addr - PERIPHERAL_BASE;
    assign win      = offset >> CHAN_SHIFT;
    assign hit      = (addr >= PERIPHERAL_BASE);
    // Comparing the whole shifted window also rejects stray high address bits.
    assign ch_valid = hit && (win < 64'(N_CHANNELS));
    assign ch       = win[CW-1:0];

endmodule

// File: rtl/core_hazard_mc.sv
// rtl/core_hazard_mc.sv - load-use hazard detect plus per-channel peripheral handshake
// Optional timeout abort of stuck requests: define HAZARD_TIMEOUT_EN.
module core_hazard_mc
    import core_hazard_pkg::*;
#(
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int          N_CHANNELS      = 4,
    parameter int          CHAN_SHIFT      = 12,
    parameter int          LOAD_LATENCY    = 1,
    parameter int          TIMEOUT_CYCLES  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            IF_rs,
    input  logic [4:0]            IF_rt,
    input  logic [4:0]            ID_W_regnum,
    input  logic                  ID_mem_read,
    input  logic [4:0]            EX_W_regnum,
    input  logic                  EX_mem_read,
    input  logic [63:0]           addr,
    input  logic                  EX_mem_write,
    input  logic                  EX_flush,
    input  logic [N_CHANNELS-1:0] d_ready,
    output logic [N_CHANNELS-1:0] d_valid,
    output logic                  d_write,
    output logic                  stall,
    output logic                  bus_err
);

    localparam int CW = chan_idx_w(N_CHANNELS);

    if (LOAD_LATENCY < LOAD_LATENCY_MIN || LOAD_LATENCY > LOAD_LATENCY_MAX) begin : g_bad_ll
        $error("core_hazard_mc: LOAD_LATENCY out of range");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
        $error("core_hazard_mc: TIMEOUT_CYCLES out of range");
    end

    hz_state_t             state;
    logic [CW-1:0]         ch_q;
    logic                  hit;
    logic                  ch_valid;
    logic [CW-1:0]         ch;
    logic [N_CHANNELS-1:0] ch_onehot;
    logic                  id_hz;
    logic                  ex_hz;
    logic                  load_use;
    logic                  preq;
`ifdef HAZARD_TIMEOUT_EN
    logic [15:0]           tmo_cnt;
`endif

    periph_chan_decode #(
        .PERIPHERAL_BASE (PERIPHERAL_BASE),
        .N_CHANNELS      (N_CHANNELS),
        .CHAN_SHIFT      (CHAN_SHIFT)
    ) u_decode (
        .addr     (addr),
        .hit      (hit),
        .ch_valid (ch_valid),
        .ch       (ch)
    );

    assign id_hz = ID_mem_read && (ID_W_regnum != 5'd0) &&
                   ((ID_W_regnum == IF_rs) || (ID_W_regnum == IF_rt));
    assign ex_hz = EX_mem_read && (EX_W_regnum != 5'd0) &&
                   ((EX_W_regnum == IF_rs) || (EX_W_regnum == IF_rt));
    // With two-cycle loads the EX/MEM load is not yet forwardable either.
    assign load_use = id_hz || ((LOAD_LATENCY == LOAD_LATENCY_MAX) && ex_hz);

    assign preq      = (EX_mem_read || EX_mem_write) && !EX_flush && hit;
    assign ch_onehot = N_CHANNELS'(1) << ch;

    assign stall = load_use || ((state == HZ_IDLE) && preq) || (state == HZ_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HZ_IDLE;
            ch_q    <= '0;
            d_valid <= '0;
            d_write <= 1'b0;
            bus_err <= 1'b0;
`ifdef HAZARD_TIMEOUT_EN
            tmo_cnt <= 16'd0;
`endif
        end else begin
            bus_err <= 1'b0;
            case (state)
                HZ_IDLE: begin
                    if (preq) begin
                        if (ch_valid) begin
                            state   <= HZ_REQ;
                            ch_q    <= ch;
                            d_write <= EX_mem_write;
                            d_valid <= ch_onehot;
`ifdef HAZARD_TIMEOUT_EN
                            tmo_cnt <= 16'd0;
`endif
                        end else begin
                            state   <= HZ_ERR;
                            bus_err <= 1'b1;
                        end
                    end
                end
                HZ_REQ: begin
                    // Ready has priority over a timeout landing on the same edge.
                    if (d_ready[ch_q]) begin
                        state   <= HZ_DONE;
                        d_valid <= '0;
                    end
`ifdef HAZARD_TIMEOUT_EN
                    else if (tmo_cnt + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
                        state   <= HZ_ERR;
                        d_valid <= '0;
                        bus_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                HZ_DONE: state <= HZ_IDLE;
                HZ_ERR:  state <= HZ_IDLE;
                default: state <= HZ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_hazard_mc.sv
// tb/tb_core_hazard_mc.sv - scoreboard bench for core_hazard_mc
module tb_core_hazard_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  IF_rs, IF_rt, ID_W_regnum, EX_W_regnum;
    logic        ID_mem_read, EX_mem_read, EX_mem_write, EX_flush;
    logic [63:0] addr;
    logic [3:0]  d_ready;
    logic [3:0]  d_valid, d_valid2;
    logic        d_write, d_write2, stall, stall2, bus_err, bus_err2;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      tag;
        logic [3:0] dv;
        logic       dw_chk;
        logic       dw;
        logic       st;
        logic       st2;
        logic       be;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    core_hazard_mc #(.LOAD_LATENCY(1), .TIMEOUT_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .IF_rs(IF_rs), .IF_rt(IF_rt),
        .ID_W_regnum(ID_W_regnum), .ID_mem_read(ID_mem_read),
        .EX_W_regnum(EX_W_regnum), .EX_mem_read(EX_mem_read),
        .addr(addr), .EX_mem_write(EX_mem_write), .EX_flush(EX_flush),
        .d_ready(d_ready), .d_valid(d_valid), .d_write(d_write),
        .stall(stall), .bus_err(bus_err)
    );

    core_hazard_mc #(.LOAD_LATENCY(2), .TIMEOUT_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .IF_rs(IF_rs), .IF_rt(IF_rt),
        .ID_W_regnum(ID_W_regnum), .ID_mem_read(ID_mem_read),
        .EX_W_regnum(EX_W_regnum), .EX_mem_read(EX_mem_read),
        .addr(addr), .EX_mem_write(EX_mem_write), .EX_flush(EX_flush),
        .d_ready(d_ready), .d_valid(d_valid2), .d_write(d_write2),
        .stall(stall2), .bus_err(bus_err2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        IF_rs = 5'd0; IF_rt = 5'd0; ID_W_regnum = 5'd0; EX_W_regnum = 5'd0;
        ID_mem_read = 1'b0; EX_mem_read = 1'b0; EX_mem_write = 1'b0;
        EX_flush = 1'b0; addr = 64'd0; d_ready = 4'd0;
    endtask

    // Push the expectation for the cycle now being driven, then compare mid-cycle.
    task automatic cyc(input string tag, input logic [3:0] dv, input logic dw_chk,
                       input logic dw, input logic st, input logic st2, input logic be);
        exp_t e;
        exp_t o;
        e.tag = tag; e.dv = dv; e.dw_chk = dw_chk; e.dw = dw;
        e.st = st; e.st2 = st2; e.be = be;
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        check({o.tag, ".d_valid"}, 64'(d_valid), 64'(o.dv));
        check({o.tag, ".stall"},   64'(stall),   64'(o.st));
        check({o.tag, ".stall2"},  64'(stall2),  64'(o.st2));
        check({o.tag, ".bus_err"}, 64'(bus_err), 64'(o.be));
        check({o.tag, ".d_valid2"}, 64'(d_valid2), 64'(o.dv));
        if (o.dw_chk) check({o.tag, ".d_write"}, 64'(d_write), 64'(o.dw));
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        check("rst.d_valid", 64'(d_valid), 64'd0);
        check("rst.d_write", 64'(d_write), 64'd0);
        check("rst.bus_err", 64'(bus_err), 64'd0);
        check("rst.stall",   64'(stall),   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Load-use on IF_rs, then dest reg 0, then IF_rt
        ID_mem_read = 1'b1; ID_W_regnum = 5'd5; IF_rs = 5'd5;
        cyc("lu_rs", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        clear_inputs();
        cyc("lu_rs_after", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ID_mem_read = 1'b1; ID_W_regnum = 5'd0; IF_rs = 5'd0;
        cyc("lu_r0", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        ID_mem_read = 1'b1; ID_W_regnum = 5'd9; IF_rt = 5'd9; IF_rs = 5'd3;
        cyc("lu_rt", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        clear_inputs();

        // EX-stage load only matters for the two-cycle latency instance
        EX_mem_read = 1'b1; EX_W_regnum = 5'd7; IF_rt = 5'd7;
        cyc("lu_ex", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        clear_inputs();

        // Read at 0x2000_1004 with ready held high
        EX_mem_read = 1'b1; addr = 64'h2000_1004; d_ready = 4'b0010;
        cyc("rd1_idle", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("rd1_req",  4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("rd1_done", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        cyc("rd1_post", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Store at 0x2000_3000, foreign ready ignored, own ready after 5 cycles
        EX_mem_write = 1'b1; addr = 64'h2000_3000;
        cyc("st3_idle", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        d_ready = 4'b0111;
        for (int i = 0; i < 4; i++)
            cyc($sformatf("st3_req%0d", i), 4'h8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        d_ready = 4'b1000;
        cyc("st3_req4", 4'h8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        d_ready = 4'b0000;
        cyc("st3_done", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        cyc("st3_post", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Out-of-range channel and stray high address bit both abort
        EX_mem_read = 1'b1; addr = 64'h2000_4000;
        cyc("inv_idle", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("inv_err",  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        clear_inputs();
        cyc("inv_post", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        EX_mem_write = 1'b1; addr = 64'h0000_0100_2000_0000;
        cyc("hi_idle", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("hi_err",  4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        clear_inputs();

        // Below base and flushed accesses are not peripheral requests
        EX_mem_read = 1'b1; addr = 64'h1FFF_FFFC;
        cyc("below", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        addr = 64'h2000_0000; EX_flush = 1'b1;
        cyc("flush", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // Load-use overlapping a channel-0 access keeps stall through DONE
        EX_mem_read = 1'b1; addr = 64'h2000_0000; d_ready = 4'b0001;
        ID_mem_read = 1'b1; ID_W_regnum = 5'd4; IF_rs = 5'd4;
        cyc("ov_idle", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("ov_req",  4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("ov_done", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        clear_inputs();
        cyc("ov_post", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Unanswered request on channel 2
        EX_mem_read = 1'b1; addr = 64'h2000_2010;
        cyc("to_idle", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef HAZARD_TIMEOUT_EN
        for (int i = 0; i < 3; i++)
            cyc($sformatf("to_req%0d", i), 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("to_err", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        for (int i = 0; i < 6; i++)
            cyc($sformatf("to_req%0d", i), 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        d_ready = 4'b0100;
        cyc("to_req_last", 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("to_done", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        clear_inputs();
        cyc("to_post", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-request drops d_valid without waiting for a clock
        EX_mem_read = 1'b1; addr = 64'h2000_1000;
        cyc("rr_idle", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("rr_req",  4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rr.d_valid", 64'(d_valid), 64'd0);
        check("rr.bus_err", 64'(bus_err), 64'd0);
        check("rr.stall_idle_preq", 64'(stall), 64'd1);
        clear_inputs();
        #1;
        check("rr.stall_idle", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("rr_post", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
